bip_debug_unit: RTL and testbench

Run-control and report stage directly downstream of the BIP `CPU`. It owns the CPU's reset and clock-enable, starts a program run on request, and watches the fetched `INSTRUCTION` for HLT. On HLT it freezes the CPU, snapshots `ADDR_PM` (halt PC), `ACC` and the run cycle count, then streams a 6-byte report frame to the UART transmitter over a valid/ready byte handshake.

---
 rtl/bip_pkg.sv | 20 ++
 rtl/bip_debug_unit_if.sv | 20 ++
 rtl/bip_debug_unit_frame_tx.sv | 52 +++++
 rtl/bip_debug_unit.sv | 119 +++++++++++
 tb/tb_bip_debug_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared BIP constants, opcode values and debug-unit state type
package bip_pkg;

    localparam int OPC_W  = 5;
    localparam int OPD_W  = 11;
    localparam int DATA_W = 16;

    localparam logic [OPC_W-1:0] OPC_HLT = 5'b00000;

    localparam int FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_SEND,
        ST_DONE
    } dbg_state_t;

endpackage

// File: rtl/bip_debug_unit_if.sv
// rtl/bip_debug_unit_if.sv - report byte stream handshake towards the UART transmitter
interface bip_debug_unit_if;

    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY
    );

endinterface

// File: rtl/bip_debug_unit_frame_tx.sv
// rtl/bip_debug_unit_frame_tx.sv - MSB-first byte serializer for the halt report frame
module debug_frame_tx #(
    parameter int NBYTES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [NBYTES*8-1:0] snapshot,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                last
);

    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    // snapshot is held stable by the caller for the whole frame, so it is read in place
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic [7:0]       cur_byte;

    // select the byte under the index, first byte being the most significant
    always_comb begin
        cur_byte = snapshot[8*(NBYTES - 1 - int'(idx_q)) +: 8];
    end

    // index/valid register: start on load, advance only on an accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            idx_q   <= '0;
        end else if (valid_q && tx_ready) begin
            if (idx_q == IDX_LAST) begin
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // outputs decoded from registered state; data reads zero while idle
    always_comb begin
        tx_valid = valid_q;
        tx_data  = valid_q ? cur_byte : 8'h00;
        last     = valid_q && tx_ready && (idx_q == IDX_LAST);
    end

endmodule

// File: rtl/bip_debug_unit.sv
// rtl/bip_debug_unit.sv - BIP run control, HLT snapshot and report frame sender
module bip_debug_unit #(
    parameter int FRAME_BYTES = bip_pkg::FRAME_BYTES
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [15:0]            INSTRUCTION,
    input  logic [10:0]            ADDR_PM,
    input  logic [15:0]            ACC,
    output logic                   CPU_EN,
    output logic                   CPU_RESET,
    output logic                   DONE,
    bip_debug_unit_if.master       tx
);

    import bip_pkg::*;

    localparam int SNAP_W = FRAME_BYTES * 8;

    dbg_state_t        state_q;
    dbg_state_t        state_n;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_inc;
    logic [OPD_W-1:0]  pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [15:0]       cyc_q;
    logic              hlt;
    logic              frame_last;
    logic [SNAP_W-1:0] snapshot;
    logic              unused_operand;

    // the operand field plays no part in run control
    assign unused_operand = ^INSTRUCTION[DATA_W-OPC_W-1:0];

    // HLT only counts while the CPU is actually running
    always_comb begin
        hlt     = (state_q == ST_RUN) && (INSTRUCTION[DATA_W-1 -: OPC_W] == OPC_HLT);
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // next state and CPU control decode
    always_comb begin
        state_n   = state_q;
        CPU_EN    = 1'b0;
        CPU_RESET = 1'b0;
        DONE      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                CPU_RESET = 1'b1;
                if (START) state_n = ST_CLR;
            end
            ST_CLR: begin
                CPU_RESET = 1'b1;
                state_n   = ST_RUN;
            end
            ST_RUN: begin
                CPU_EN = 1'b1;
                if (hlt) state_n = ST_SEND;
            end
            ST_SEND: begin
                if (frame_last) state_n = ST_DONE;
            end
            ST_DONE: begin
                DONE = 1'b1;
                if (START) state_n = ST_CLR;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // cycle counter and halt snapshot; the count captured includes the HLT cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
            pc_q  <= '0;
            acc_q <= '0;
            cyc_q <= '0;
        end else if (state_q == ST_CLR) begin
            cnt_q <= '0;
            pc_q  <= '0;
            acc_q <= '0;
            cyc_q <= '0;
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_inc;
            if (hlt) begin
                pc_q  <= ADDR_PM;
                acc_q <= ACC;
                cyc_q <= cnt_inc;
            end
        end
    end

    assign snapshot = SNAP_W'({5'b00000, pc_q, acc_q, cyc_q});

    // serializer starts on the HLT edge so byte 1 is valid in the first frozen cycle
    debug_frame_tx #(
        .NBYTES   (FRAME_BYTES)
    ) u_frame_tx (
        .clk      (CLK),
        .rst      (RESET),
        .load     (hlt),
        .snapshot (snapshot),
        .tx_data  (tx.TX_DATA),
        .tx_valid (tx.TX_VALID),
        .tx_ready (tx.TX_READY),
        .last     (frame_last)
    );

endmodule

// File: tb/tb_bip_debug_unit.sv
// tb/tb_bip_debug_unit.sv - randomized self-checking bench for bip_debug_unit
module tb_bip_debug_unit;

    import bip_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] INSTRUCTION;
    logic [10:0] ADDR_PM;
    logic [15:0] ACC;
    logic        CPU_EN;
    logic        CPU_RESET;
    logic        DONE;

    bip_debug_unit_if tx ();

    bip_debug_unit #(
        .FRAME_BYTES (6)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .INSTRUCTION (INSTRUCTION),
        .ADDR_PM     (ADDR_PM),
        .ACC         (ACC),
        .CPU_EN      (CPU_EN),
        .CPU_RESET   (CPU_RESET),
        .DONE        (DONE),
        .tx          (tx.master)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] non_hlt_instr();
        logic [4:0]  opc;
        logic [10:0] opd;
        opc = 5'($urandom_range(1, 31));
        opd = 11'($urandom);
        return {opc, opd};
    endfunction

    // mode: 0 ready high, 1 random ready and stray STARTs, 2 three-cycle stall on byte 3, 3 reset after two bytes
    task automatic run_frame(input int n_pre, input logic [10:0] pc, input logic [15:0] acc, input int mode);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int         cyc_exp;
        int         cycles;
        int         stall;
        bit         en_ok;
        bit         pending;
        logic [7:0] pdata;
        logic       r;

        // expected report frame straight from the frame format
        cyc_exp = (n_pre + 1 > 65535) ? 65535 : n_pre + 1;
        exp_q.push_back(8'(pc / 256));
        exp_q.push_back(8'(pc % 256));
        exp_q.push_back(8'(acc / 256));
        exp_q.push_back(8'(acc % 256));
        exp_q.push_back(8'(cyc_exp / 256));
        exp_q.push_back(8'(cyc_exp % 256));

        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check_eq("clr_cpu_en", 32'(CPU_EN), 32'd0);
        check_eq("clr_cpu_reset", 32'(CPU_RESET), 32'd1);
        check_eq("clr_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        check_eq("run_cpu_en", 32'(CPU_EN), 32'd1);
        check_eq("run_cpu_reset", 32'(CPU_RESET), 32'd0);

        en_ok = 1'b1;
        for (int i = 0; i < n_pre; i++) begin
            INSTRUCTION = non_hlt_instr();
            ADDR_PM     = 11'($urandom);
            ACC         = 16'($urandom);
            START       = (mode == 1) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge CLK);
            if (CPU_EN !== 1'b1) en_ok = 1'b0;
        end
        check_eq("run_en_held", 32'(en_ok), 32'd1);

        INSTRUCTION = {OPC_HLT, 11'($urandom)};
        ADDR_PM     = pc;
        ACC         = acc;
        START       = 1'b0;
        @(negedge CLK);
        INSTRUCTION = non_hlt_instr();
        ACC         = 16'($urandom);
        ADDR_PM     = 11'($urandom);
        check_eq("hlt_freeze", 32'(CPU_EN), 32'd0);
        check_eq("hlt_first_valid", 32'(tx.TX_VALID), 32'd1);

        cycles  = 0;
        stall   = 0;
        pending = 1'b0;
        pdata   = 8'h00;
        while (got_q.size() < 6 && cycles < 300) begin
            if (pending) begin
                check_eq("hold_valid", 32'(tx.TX_VALID), 32'd1);
                check_eq("hold_data", 32'(tx.TX_DATA), 32'(pdata));
            end
            if (mode == 3 && got_q.size() == 2) break;
            case (mode)
                1:       r = 1'($urandom_range(0, 1));
                2:       r = (got_q.size() == 2 && stall < 3) ? 1'b0 : 1'b1;
                default: r = 1'b1;
            endcase
            if (mode == 2 && !r) stall++;
            START = (mode == 1) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            tx.TX_READY = r;
            if (tx.TX_VALID && r) got_q.push_back(tx.TX_DATA);
            pending = tx.TX_VALID && !r;
            pdata   = tx.TX_DATA;
            @(negedge CLK);
            cycles++;
        end
        START = 1'b0;

        if (mode == 3) begin
            RESET = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            check_eq("rst_send_valid", 32'(tx.TX_VALID), 32'd0);
            check_eq("rst_send_cpu_reset", 32'(CPU_RESET), 32'd1);
            check_eq("rst_send_done", 32'(DONE), 32'd0);
            check_eq("rst_send_nbytes", 32'(got_q.size()), 32'd2);
            for (int i = 0; i < got_q.size(); i++) check_eq("rst_send_byte", 32'(got_q[i]), 32'(exp_q[i]));
            @(negedge CLK);
            check_eq("rst_send_no_resume", 32'(tx.TX_VALID), 32'd0);
            return;
        end

        check_eq("frame_len", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < got_q.size() && i < 6; i++) check_eq($sformatf("byte%0d", i + 1), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq("done_flag", 32'(DONE), 32'd1);
        check_eq("done_cpu_en", 32'(CPU_EN), 32'd0);
        check_eq("done_cpu_reset", 32'(CPU_RESET), 32'd0);
        check_eq("done_valid", 32'(tx.TX_VALID), 32'd0);
        if (mode == 0) check_eq("frame_cycles", 32'(cycles), 32'd6);
        if (mode == 2) check_eq("stall_cycles", 32'(stall), 32'd3);
    endtask

    initial begin
        bit idle_ok;

        RESET       = 1'b1;
        START       = 1'b0;
        INSTRUCTION = 16'h0800;
        ADDR_PM     = '0;
        ACC         = '0;
        tx.TX_READY = 1'b0;
        repeat (5) @(negedge CLK);
        check_eq("rst_cpu_reset", 32'(CPU_RESET), 32'd1);
        check_eq("rst_cpu_en", 32'(CPU_EN), 32'd0);
        check_eq("rst_valid", 32'(tx.TX_VALID), 32'd0);
        check_eq("rst_data", 32'(tx.TX_DATA), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        RESET = 1'b0;

        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (CPU_RESET !== 1'b1 || CPU_EN !== 1'b0 || tx.TX_VALID !== 1'b0 || DONE !== 1'b0) idle_ok = 1'b0;
        end
        check_eq("idle_20", 32'(idle_ok), 32'd1);

        run_frame(4, 11'd5, 16'h0013, 0);
        run_frame(6, 11'h123, 16'hA55A, 2);
        run_frame(0, 11'd0, 16'h0000, 0);

        // RESET beats START while sitting in DONE
        RESET = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        check_eq("rst_start_done", 32'(DONE), 32'd0);
        check_eq("rst_start_cpu_reset", 32'(CPU_RESET), 32'd1);
        @(negedge CLK);
        check_eq("rst_start_no_clr", 32'(CPU_EN), 32'd0);
        @(negedge CLK);
        check_eq("rst_start_no_run", 32'(CPU_EN), 32'd0);

        run_frame(3, 11'h042, 16'h1234, 3);
        run_frame(2, 11'h042, 16'h1234, 0);

        repeat (8) run_frame(int'($urandom_range(0, 30)), 11'($urandom), 16'($urandom), 1);

        run_frame(70000, 11'h7FF, 16'hBEEF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
